// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants.
// Entry struct pairs each buffered instruction with its PC.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int DROP_W = 8;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO buffering fetched instructions.
// Flush wins over push/pop; push+pop when full is legal.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, response buffer
// and decode-facing output register with redirect flush.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              xlen       = XLEN,
    parameter logic [xlen-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    output logic [xlen-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [xlen-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [xlen-1:0] redirect_pc,
    input  logic            decode_ready,
    output logic [xlen-1:0] current_instruction,
    output logic [xlen-1:0] current_pc,
    output logic            instr_valid
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              r_run;
    logic [xlen-1:0]   r_pc;
    logic [xlen-1:0]   r_rsp_pc;
    logic [CW-1:0]     r_in_flight;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_cur_valid;
    logic [xlen-1:0]   r_cur_instr;
    logic [xlen-1:0]   r_cur_pc;

    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_used;
    logic              w_empty;
    logic              w_issue;
    logic              w_accept;
    logic              w_rsp_drop;
    logic              w_rsp_keep;
    logic              w_rsp_any;
    logic              w_can_load;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic [xlen-1:0]   w_redir_pc;
    fetch_entry_t      w_rsp_entry;
    fetch_entry_t      w_head;

    // Credits cover in-flight plus buffered, so responses never overflow.
    assign w_used     = r_in_flight + w_count;
    assign w_issue    = r_run & (w_used < CW'(FIFO_DEPTH)) & ~redirect_valid;
    assign w_accept   = w_issue & imem_req_ready;
    assign w_rsp_drop = imem_rsp_valid & (r_drop_cnt != '0);
    assign w_rsp_keep = imem_rsp_valid & (r_drop_cnt == '0)
                      & (r_in_flight != '0);
    assign w_rsp_any  = w_rsp_drop | w_rsp_keep;
    assign w_can_load = ~r_cur_valid | decode_ready;
    assign w_bypass   = w_rsp_keep & w_empty & w_can_load;
    assign w_push     = w_rsp_keep & ~w_bypass & ~redirect_valid;
    assign w_pop      = w_can_load & ~w_empty & ~redirect_valid;
    assign w_redir_pc = redirect_pc & ~xlen'(3);

    assign w_rsp_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_rsp_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_run       <= 1'b0;
            r_pc        <= RESET_PC;
            r_rsp_pc    <= RESET_PC;
            r_in_flight <= '0;
            r_drop_cnt  <= '0;
            r_cur_valid <= 1'b0;
            r_cur_instr <= NOP_INSTR;
            r_cur_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            r_run       <= 1'b1;
            r_pc        <= w_redir_pc;
            r_rsp_pc    <= w_redir_pc;
            r_drop_cnt  <= r_drop_cnt + DROP_W'(r_in_flight)
                         + DROP_W'(w_accept) - DROP_W'(w_rsp_any);
            r_in_flight <= '0;
            r_cur_valid <= 1'b0;
            r_cur_instr <= NOP_INSTR;
        end else begin
            r_run       <= 1'b1;
            r_in_flight <= r_in_flight + CW'(w_accept) - CW'(w_rsp_keep);
            if (w_accept)   r_pc       <= r_pc + xlen'(4);
            if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + xlen'(4);
            if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - DROP_W'(1);
            // Buffered entries are older than a fresh response.
            if (w_pop) begin
                r_cur_valid <= 1'b1;
                r_cur_instr <= w_head.instr;
                r_cur_pc    <= w_head.pc;
            end else if (w_bypass) begin
                r_cur_valid <= 1'b1;
                r_cur_instr <= imem_rsp_data;
                r_cur_pc    <= r_rsp_pc;
            end else if (r_cur_valid && decode_ready) begin
                r_cur_valid <= 1'b0;
                r_cur_instr <= NOP_INSTR;
            end
        end
    end

    assign imem_req_valid      = w_issue;
    assign imem_req_addr       = r_pc;
    assign instr_valid         = r_cur_valid;
    assign current_instruction = r_cur_instr;
    assign current_pc          = r_cur_pc;

endmodule
